// File: rtl/sched_pkg.sv
// Shared constants, FSM encoding and one-hot encoder for the FIFO read scheduler.
package sched_pkg;

  localparam int unsigned NUM_CH     = 8;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned BUF_CNT_W  = 2;
  localparam int unsigned STARVE_MAX = 15;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] READ = 1'b1;

  // OR-reduction encoder; only meaningful for one-hot (or zero) input
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_CH-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sched_out_buf.sv
// Two-entry FIFO-ordered egress buffer with valid/ready handshake and occupancy count.
module sched_out_buf
  import sched_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [DATA_W-1:0]    push_data_i,
  input  logic [IDX_W-1:0]     push_ch_i,
  output logic [DATA_W-1:0]    out_data_o,
  output logic [IDX_W-1:0]     out_ch_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [BUF_CNT_W-1:0] cnt_o
);

  logic [DATA_W-1:0]    mem_data_q [2];
  logic [IDX_W-1:0]     mem_ch_q   [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [BUF_CNT_W-1:0] cnt_q, cnt_d;
  logic                 pop_c;

  assign pop_c       = out_valid_o & out_ready_i;
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = mem_data_q[rd_ptr_q];
  assign out_ch_o    = mem_ch_q[rd_ptr_q];
  assign cnt_o       = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_c)  rd_ptr_d = ~rd_ptr_q;
    case ({push_i, pop_c})
      2'b10:   cnt_d = cnt_q + BUF_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - BUF_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        mem_data_q[i] <= '0;
        mem_ch_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_i) begin
        mem_data_q[wr_ptr_q] <= push_data_i;
        mem_ch_q[wr_ptr_q]   <= push_ch_i;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_sched.sv
// Grant-lock / burst-read scheduler feeding a 2-entry egress buffer.
// Optional anti-starvation override enabled by SCHED_ANTISTARVE_EN.
module fifo_rd_sched
  import sched_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          select,
  input  logic [NUM_CH-1:0]          ch_empty,
  output logic [NUM_CH-1:0]          ch_rd_en,
  input  logic [NUM_CH*DATA_W-1:0]   ch_rd_data,
  output logic [DATA_W-1:0]          out_data,
  output logic [IDX_W-1:0]           out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy
);

  logic [0:0]           state_q, state_d;
  logic [NUM_CH-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]     gidx_q, gidx_d;
  logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]     pend_idx_q, pend_idx_d;

  logic [NUM_CH-1:0]    lock_mask_c;
  logic [IDX_W-1:0]     lock_idx_c;
  logic                 lock_c;
  logic                 issue_c;
  logic [2:0]           credit_c;
  logic [BUF_CNT_W-1:0] buf_cnt_c;
  logic [DATA_W-1:0]    push_data_c;

`ifdef SCHED_ANTISTARVE_EN
  logic [CNT_W-1:0] wait_cnt_q [NUM_CH];
  logic [CNT_W-1:0] wait_cnt_d [NUM_CH];
  logic             starve_hit_c;
  logic [IDX_W-1:0] starve_idx_c;

  // Downward scan so the lowest starved, non-empty channel wins
  always_comb begin
    starve_hit_c = 1'b0;
    starve_idx_c = '0;
    for (int k = int'(NUM_CH) - 1; k >= 0; k--) begin
      if (wait_cnt_q[k] == CNT_W'(STARVE_MAX) && !ch_empty[k]) begin
        starve_hit_c = 1'b1;
        starve_idx_c = IDX_W'(k);
      end
    end
  end

  assign lock_mask_c = starve_hit_c ? (NUM_CH'(1) << starve_idx_c) : select;

  always_comb begin
    for (int k = 0; k < int'(NUM_CH); k++) begin
      wait_cnt_d[k] = wait_cnt_q[k];
      if (state_q == IDLE && lock_c) begin
        if (lock_idx_c == IDX_W'(k)) begin
          wait_cnt_d[k] = '0;
        end else if (!ch_empty[k] && wait_cnt_q[k] != CNT_W'(STARVE_MAX)) begin
          wait_cnt_d[k] = wait_cnt_q[k] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (rst) wait_cnt_q[k] <= '0;
      else     wait_cnt_q[k] <= wait_cnt_d[k];
    end
  end
`else
  assign lock_mask_c = select;
`endif

  assign lock_idx_c = onehot_to_idx(lock_mask_c);
  assign lock_c     = |(lock_mask_c & ~ch_empty);

  // Credit includes the slot freed by a same-cycle pop so a burst streams at 1 word/cycle
  assign credit_c = 3'(buf_cnt_c) + 3'(rd_pend_q) - 3'(out_valid & out_ready);
  assign issue_c  = (state_q == READ) && !ch_empty[gidx_q]
                 && (burst_cnt_q < CNT_W'(BURST_LEN)) && (credit_c < 3'd2);

  assign ch_rd_en = issue_c ? grant_q : '0;
  assign busy     = (state_q != IDLE) | rd_pend_q;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    gidx_d      = gidx_q;
    burst_cnt_d = burst_cnt_q;
    rd_pend_d   = issue_c;
    pend_idx_d  = gidx_q;
    case (state_q)
      IDLE: begin
        if (lock_c) begin
          grant_d     = lock_mask_c;
          gidx_d      = lock_idx_c;
          burst_cnt_d = '0;
          state_d     = READ;
        end
      end
      READ: begin
        if (issue_c) begin
          burst_cnt_d = burst_cnt_q + CNT_W'(1);
          if (burst_cnt_q + CNT_W'(1) == CNT_W'(BURST_LEN)) state_d = IDLE;
        end else if (ch_empty[gidx_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      gidx_q      <= '0;
      burst_cnt_q <= '0;
      rd_pend_q   <= 1'b0;
      pend_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      gidx_q      <= gidx_d;
      burst_cnt_q <= burst_cnt_d;
      rd_pend_q   <= rd_pend_d;
      pend_idx_q  <= pend_idx_d;
    end
  end

  always_comb begin
    push_data_c = '0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (pend_idx_q == IDX_W'(k)) push_data_c = ch_rd_data[k*DATA_W +: DATA_W];
    end
  end

  sched_out_buf #(.DATA_W(DATA_W)) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .push_i      (rd_pend_q),
    .push_data_i (push_data_c),
    .push_ch_i   (pend_idx_q),
    .out_data_o  (out_data),
    .out_ch_o    (out_ch),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .cnt_o       (buf_cnt_c)
  );

endmodule
